// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed register memory with byte strobes.
// Write and read channels run independent FSMs; out-of-range words return SLVERR.

module axi_lite_slave_mem_lane #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [7:0]       wr_byte,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [7:0]       rd_byte
);
  logic [DEPTH-1:0][7:0] mem;

  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n)  mem <= '0;
    else if (we)  mem[wr_idx] <= wr_byte;

  // Combinational read so a same-edge write is seen only on the following read.
  assign rd_byte = mem[rd_idx];
endmodule

module axi_lite_slave_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int WI_W      = ADDR_WIDTH - 2;
  localparam logic [WI_W-1:0] DEPTH_LIM = WI_W'(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [WI_W-1:0]           idx;
    logic [NUM_LANES-1:0][7:0] data;
    logic [NUM_LANES-1:0]      strb;
  } wr_req_t;

  typedef struct packed {
    logic [NUM_LANES-1:0][7:0] data;
    logic [1:0]                resp;
  } rd_rsp_t;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  // Only aligned accesses exist, so the byte-offset bits carry no meaning.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

  // ---------------- write channel ----------------
  w_state_t w_state, w_next;
  wr_req_t  wr_q;
  logic     aw_held, w_held, commit, aw_ok;
  logic     bvalid_q;
  logic [1:0] bresp_q;
  logic     aw_hs, w_hs;

  assign AWREADY = (w_state == W_IDLE) && !aw_held;
  assign WREADY  = (w_state == W_IDLE) && !w_held;
  assign aw_hs   = AWVALID && AWREADY;
  assign w_hs    = WVALID && WREADY;
  assign aw_ok   = wr_q.idx < DEPTH_LIM;

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) w_state <= W_IDLE;
    else          w_state <= w_next;

  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    case (w_state)
      W_IDLE: if (aw_held && w_held) begin
        commit = 1'b1;
        w_next = W_RESP;
      end
      W_RESP: if (bvalid_q && BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Readies are low during the commit cycle, so capture and clear never collide.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      wr_q    <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        wr_q.idx <= AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held    <= 1'b1;
        wr_q.data <= WDATA;
        wr_q.strb <= WSTRB;
      end
    end

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bvalid_q && BREADY) begin
      bvalid_q <= 1'b0;
    end

  assign BVALID = bvalid_q;
  assign BRESP  = bresp_q;

  // ---------------- read channel ----------------
  r_state_t r_state, r_next;
  rd_rsp_t  rd_q;
  logic     rvalid_q, ar_hs, ar_ok;
  logic [WI_W-1:0]           ar_idx;
  logic [NUM_LANES-1:0][7:0] rd_word;

  assign ARREADY = (r_state == R_IDLE);
  assign ar_hs   = ARVALID && ARREADY;
  assign ar_idx  = ARADDR[ADDR_WIDTH-1:2];
  assign ar_ok   = ar_idx < DEPTH_LIM;

  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_state <= R_IDLE;
    else          r_state <= r_next;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (rvalid_q && RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // RDATA keeps its last value after the handshake until the next AR.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      rvalid_q <= 1'b0;
      rd_q     <= '0;
    end else if (ar_hs) begin
      rvalid_q  <= 1'b1;
      rd_q.data <= ar_ok ? rd_word : '0;
      rd_q.resp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (rvalid_q && RREADY) begin
      rvalid_q <= 1'b0;
    end

  assign RVALID = rvalid_q;
  assign RDATA  = rd_q.data;
  assign RRESP  = rd_q.resp;

  // ---------------- byte-lane storage ----------------
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    axi_lite_slave_mem_lane #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
    ) u_lane (
      .gclk    (PCLK),
      .grst_n  (PRESETn),
      .we      (commit && aw_ok && wr_q.strb[i]),
      .wr_idx  (wr_q.idx[IDX_W-1:0]),
      .wr_byte (wr_q.data[i]),
      .rd_idx  (ar_idx[IDX_W-1:0]),
      .rd_byte (rd_word[i])
    );
  end
endmodule

// File: doc/axi_lite_slave_mem.md
Name: axi_lite_slave_mem

Overview:
AXI4-Lite slave with a word-addressed register memory. It is the design-under-test whose channel signals feed the slave-side protocol checker. It serves single-beat writes and reads from the interconnect/master, supports byte strobes, and returns SLVERR for out-of-range addresses. The write and read channels are fully independent.

Parameters:
ADDR_WIDTH, 8, byte address width of AWADDR/ARADDR
DATA_WIDTH, 32, data bus width; only 32 supported (4 strobe bits)
DEPTH, 16, number of DATA_WIDTH-bit words; word index = ADDR[ADDR_WIDTH-1:2]

Ports:
PCLK  in  1  clock, rising edge
PRESETn  in  1  asynchronous active-low reset
AWADDR  in  ADDR_WIDTH  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_WIDTH  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset (async assert, sync release): all memory words = 0; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0; aw_held=w_held=0; both FSMs return to IDLE. A reset mid-transaction drops any pending VALID immediately and discards held address/data.
- Handshake: a transfer occurs on a rising edge where VALID&&READY. Outputs are registered. Once asserted, BVALID/RVALID and their payload stay stable until READY is sampled.
- Write FSM, states W_IDLE, W_RESP.
  - In W_IDLE: AWREADY = !aw_held; WREADY = !w_held. Each handshake captures AWADDR or WDATA/WSTRB and sets its held flag. AW and W may arrive in either order or in the same cycle.
  - When aw_held&&w_held, the next edge commits the write and the FSM moves to W_RESP.
  - Commit: for each byte i with WSTRB[i]=1, write WDATA byte i. WSTRB=0 writes nothing but still returns OKAY. Set BVALID=1, clear both held flags.
  - BRESP = SLVERR if word index >= DEPTH (memory untouched), else OKAY.
  - Latency: if AW and W handshake on edge T, BVALID=1 after edge T+1.
  - In W_RESP: AWREADY=WREADY=0. On BVALID&&BREADY the FSM returns to W_IDLE and BVALID=0. There is no back-to-back response in the same cycle.
- Read FSM, states R_IDLE, R_DATA.
  - ARREADY = (state==R_IDLE).
  - On AR handshake at edge T: RDATA = mem[index] (0 if out of range), RRESP = OKAY or SLVERR, RVALID=1 after edge T, state R_DATA.
  - On RVALID&&RREADY: return to R_IDLE, RVALID=0. RDATA is held at its last value.
- Address bits [1:0] are ignored (aligned access only).
- Read and write of the same word on the same edge: the read returns the pre-write value.
- Read and write channels never stall each other.

Test Plan:
- Reset then read addr 0x04 with RREADY=1 -> ARREADY=1; RVALID one cycle after the AR handshake; RDATA=0x00000000, RRESP=00.
- AW 0x08 and W 0xDEADBEEF/WSTRB=F in the same cycle, BREADY=1 -> BVALID=1 two edges later with BRESP=00. A subsequent read of 0x08 returns 0xDEADBEEF.
- W before AW (W at cycle 1, AW at cycle 4) to 0x0C, data 0x11223344, WSTRB=0101 over an initial 0xAABBCCDD -> read 0x0C returns 0xAA22CC44. WREADY=0 from cycle 2 until the response completes.
- Write 0x40 (index 16, beyond DEPTH) -> BRESP=10, no memory word changes. Read 0x40 -> RRESP=10, RDATA=0.
- BREADY/RREADY held low for 5 cycles -> BVALID/RVALID and BRESP/RDATA stay stable; AWREADY=WREADY=0 and ARREADY=0 throughout.
- Assert PRESETn=0 while BVALID=1 and RVALID=1 -> both drop in the same cycle (async). After release, AWREADY=WREADY=ARREADY=1 and previously written words read as 0.
